// File: rtl/tis_port_endpoint_if.sv
// rtl/tis_port_endpoint_if.sv - host/node port bundle for tis_port_endpoint
// master drives host and node stimulus, slave is the endpoint.
interface tis_port_endpoint_if #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
);
  logic [0:DATA_W-1] host_tx_data;
  logic              host_tx_valid;
  logic              host_tx_ready;
  logic [0:DATA_W-1] node_in_data;
  logic              node_in_valid;
  logic              node_in_ready;
  logic [0:DATA_W-1] node_out_data;
  logic              node_out_valid;
  logic              node_out_ready;
  logic [0:DATA_W-1] host_rx_data;
  logic              host_rx_valid;
  logic              host_rx_ready;
  logic [0:AW]       tx_count;
  logic [0:AW]       rx_count;
  logic              range_err;

  modport slave (
    input  host_tx_data, host_tx_valid, node_in_ready,
    input  node_out_data, node_out_valid, host_rx_ready,
    output host_tx_ready, node_in_data, node_in_valid,
    output node_out_ready, host_rx_data, host_rx_valid,
    output tx_count, rx_count, range_err
  );

  modport master (
    output host_tx_data, host_tx_valid, node_in_ready,
    output node_out_data, node_out_valid, host_rx_ready,
    input  host_tx_ready, node_in_data, node_in_valid,
    input  node_out_ready, host_rx_data, host_rx_valid,
    input  tx_count, rx_count, range_err
  );
endinterface

// File: rtl/tis_port_endpoint.sv
// rtl/tis_port_endpoint.sv - buffered TX/RX endpoint for one TIS-100 node port pair
// Optional TIS_PORT_CLAMP_EN: saturate TX words, flag out-of-range RX words.
module tis_port_fifo #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:DATA_W-1] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [0:DATA_W-1] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:AW]       count
);
  logic [0:DATA_W-1] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  // Full blocks a push even when a pop lands in the same cycle; no empty bypass.
  assign in_ready  = !rst && (count != (AW+1)'(DEPTH));
  assign out_valid = !rst && (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end
endmodule

module tis_port_endpoint #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  tis_port_endpoint_if.slave bus
);
  logic [0:DATA_W-1] tx_wdata;

`ifdef TIS_PORT_CLAMP_EN
  localparam logic signed [DATA_W-1:0] WORD_MAX = DATA_W'(999);
  localparam logic signed [DATA_W-1:0] WORD_MIN = DATA_W'(-999);
  logic rx_push;
  logic rx_oor;

  always_comb begin
    tx_wdata = bus.host_tx_data;
    if ($signed(bus.host_tx_data) > WORD_MAX)      tx_wdata = WORD_MAX;
    else if ($signed(bus.host_tx_data) < WORD_MIN) tx_wdata = WORD_MIN;
  end

  // RX words are stored verbatim; only the sticky flag records the violation.
  assign rx_push = bus.node_out_valid && bus.node_out_ready;
  assign rx_oor  = ($signed(bus.node_out_data) > WORD_MAX) ||
                   ($signed(bus.node_out_data) < WORD_MIN);

  always_ff @(posedge clk) begin
    if (rst)                   bus.range_err <= 1'b0;
    else if (rx_push && rx_oor) bus.range_err <= 1'b1;
  end
`else
  assign tx_wdata      = bus.host_tx_data;
  assign bus.range_err = 1'b0;
`endif

  tis_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   (tx_wdata),
    .in_valid  (bus.host_tx_valid),
    .in_ready  (bus.host_tx_ready),
    .out_data  (bus.node_in_data),
    .out_valid (bus.node_in_valid),
    .out_ready (bus.node_in_ready),
    .count     (bus.tx_count)
  );

  tis_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   (bus.node_out_data),
    .in_valid  (bus.node_out_valid),
    .in_ready  (bus.node_out_ready),
    .out_data  (bus.host_rx_data),
    .out_valid (bus.host_rx_valid),
    .out_ready (bus.host_rx_ready),
    .count     (bus.rx_count)
  );
endmodule
